// File: rtl/spi_slave_param.sv
// spi_slave_param
// Single-clock serial slave. It shifts in one frame of N_WORDS x DATA_W bits
// on SIMO while CSS is low, then offers the frame on a valid/ready port.
// It then waits for one DATA_W-bit result word and returns it on SOMI.
// Every state change and shift happens on the rising edge of clk.
// Deasserting CSS mid-transfer aborts the transfer and raises frame_err for
// one cycle.

module spi_slave_param #(
   parameter int DATA_W    = 128,
   parameter int N_WORDS   = 2,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      SIMO,
   input  logic                      CSS,
   input  logic                      mode,
   output logic                      SOMI,
   output logic [N_WORDS*DATA_W-1:0] rx_data,
   output logic                      rx_mode,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   input  logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      frame_err,
   output logic                      busy
);

   localparam int TOTAL = N_WORDS * DATA_W;
   // The counter can hold TOTAL itself, so it never wraps within a frame.
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   typedef enum logic [2:0] {IDLE, RECV, HAND, WAIT_TX, SEND} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TOTAL-1:0]  rx_sr_q, rx_sr_d;
   logic [TOTAL-1:0]  rx_data_q, rx_data_d;
   logic              rx_mode_q, rx_mode_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic              frame_err_q, frame_err_d;

   logic [CNT_W-1:0]  bit_n;
   logic [IDX_W-1:0]  bit_idx;
   logic              last_bit;
   logic              send_done;

   // Map wire bit n to its position in the frame.
   // Word n/DATA_W is written LSB-up or MSB-down, depending on LSB_FIRST.
   function automatic int wire_to_pos(input int n);
      int word;
      int ofs;
      word = n / DATA_W;
      ofs  = n % DATA_W;
      return LSB_FIRST ? (word * DATA_W + ofs) : (word * DATA_W + DATA_W - 1 - ofs);
   endfunction

   // Decode which frame bit this edge samples and whether it completes the frame or the reply
   always_comb begin
      bit_n     = (state_q == RECV) ? cnt_q : '0;
      last_bit  = (bit_n == CNT_W'(TOTAL - 1));
      bit_idx   = IDX_W'(wire_to_pos(int'(bit_n)));
      send_done = (cnt_q == CNT_W'(DATA_W - 1));
   end

   // State register; reset forces IDLE at once, even mid-frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; CSS is only looked at while a transfer is in progress or from IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!CSS) state_d = last_bit ? HAND : RECV;
         RECV:    if (CSS) state_d = IDLE;
                  else if (last_bit) state_d = HAND;
         HAND:    if (rx_ready) state_d = WAIT_TX;
         WAIT_TX: if (tx_valid) state_d = SEND;
         SEND:    if (CSS || send_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers; every one of them clears on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_mode_q   <= 1'b0;
         tx_sr_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         rx_data_q   <= rx_data_d;
         rx_mode_q   <= rx_mode_d;
         tx_sr_q     <= tx_sr_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Shift bits in or out and count them.
   // Bits gather in rx_sr so an aborted frame never disturbs rx_data.
   always_comb begin
      cnt_d       = cnt_q;
      rx_sr_d     = rx_sr_q;
      rx_data_d   = rx_data_q;
      rx_mode_d   = rx_mode_q;
      tx_sr_d     = tx_sr_q;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE, RECV: begin
            if (!CSS) begin
               rx_sr_d[bit_idx] = SIMO;
               if (last_bit) begin
                  rx_data_d = rx_sr_d;
                  rx_mode_d = mode;
                  cnt_d     = '0;
               end else begin
                  cnt_d = bit_n + CNT_W'(1);
               end
            end else if (state_q == RECV) begin
               cnt_d       = '0;
               frame_err_d = 1'b1;
            end
         end
         WAIT_TX: begin
            if (tx_valid) begin
               tx_sr_d = tx_data;
               cnt_d   = '0;
            end
         end
         SEND: begin
            if (CSS) begin
               cnt_d       = '0;
               frame_err_d = 1'b1;
            end else begin
               tx_sr_d = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
               cnt_d   = send_done ? '0 : cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from registered state; SOMI is held low outside SEND
   always_comb begin
      busy      = (state_q != IDLE);
      rx_valid  = (state_q == HAND);
      tx_ready  = (state_q == WAIT_TX);
      SOMI      = (state_q == SEND) ? (LSB_FIRST ? tx_sr_q[0] : tx_sr_q[DATA_W-1]) : 1'b0;
      rx_data   = rx_data_q;
      rx_mode   = rx_mode_q;
      frame_err = frame_err_q;
   end

endmodule
